// File: rtl/writeback_arbiter_if.sv
// Write-back bus bundle: ALU and LSU result channels, issue tracking,
// and the registered register-file write port.
interface writeback_arbiter_if;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        issue_en;
  logic [4:0]  issue_rd;
  logic [31:0] busy;
  logic        reg_write_en;
  logic [4:0]  rd_addr;
  logic [31:0] write_data;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output lsu_valid, lsu_rd, lsu_data,
    output issue_en, issue_rd,
    input  alu_ready, lsu_ready, busy,
    input  reg_write_en, rd_addr, write_data
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  lsu_valid, lsu_rd, lsu_data,
    input  issue_en, issue_rd,
    output alu_ready, lsu_ready, busy,
    output reg_write_en, rd_addr, write_data
  );
endinterface

// File: rtl/writeback_arbiter.sv
// Arbitrates ALU results and buffered LSU results onto the single register-file
// write port, and tracks long-latency destinations in a pending-write bitmap.
module writeback_arbiter #(
  parameter int QUEUE_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  writeback_arbiter_if.slave bus
);

  localparam int AW = $clog2(QUEUE_DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [4:0]    fifo_rd   [QUEUE_DEPTH];
  logic [31:0]   fifo_data [QUEUE_DEPTH];
  logic          fifo_empty;
  logic          fifo_full;
  logic          push;
  logic          pop;
  logic [4:0]    head_rd;
  logic [31:0]   head_data;

  logic          contended;
  logic          grant_alu;
  logic          grant_lsu;
  logic          last_grant_lsu;

  logic          wen_q;
  logic [4:0]    rd_q;
  logic [31:0]   data_q;
  logic          from_lsu_q;
  logic [31:0]   busy_q;
  logic [31:0]   busy_nxt;

  // Pointer MSB distinguishes full from empty when the index bits match.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push       = bus.lsu_valid && !fifo_full;
  assign head_rd    = fifo_rd[rd_ptr[AW-1:0]];
  assign head_data  = fifo_data[rd_ptr[AW-1:0]];

  // On contention the source that did not win last time gets the port.
  assign contended  = bus.alu_valid && !fifo_empty;
  assign grant_alu  = bus.alu_valid && (fifo_empty || last_grant_lsu);
  assign grant_lsu  = !fifo_empty && !grant_alu;
  assign pop        = grant_lsu;

  assign bus.alu_ready    = grant_alu;
  assign bus.lsu_ready    = !fifo_full;
  assign bus.busy         = busy_q;
  assign bus.reg_write_en = wen_q;
  assign bus.rd_addr      = rd_q;
  assign bus.write_data   = data_q;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wr_ptr[AW-1:0]]   <= bus.lsu_rd;
      fifo_data[wr_ptr[AW-1:0]] <= bus.lsu_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      last_grant_lsu <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (contended) last_grant_lsu <= grant_lsu;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wen_q      <= 1'b0;
      rd_q       <= '0;
      data_q     <= '0;
      from_lsu_q <= 1'b0;
    end else if (grant_alu) begin
      wen_q      <= (bus.alu_rd != 5'd0);
      rd_q       <= bus.alu_rd;
      data_q     <= bus.alu_data;
      from_lsu_q <= 1'b0;
    end else if (grant_lsu) begin
      wen_q      <= (head_rd != 5'd0);
      rd_q       <= head_rd;
      data_q     <= head_data;
      from_lsu_q <= 1'b1;
    end else begin
      wen_q      <= 1'b0;
      from_lsu_q <= 1'b0;
    end
  end

  // Clear on the commit edge of an LSU write; a same-edge issue re-arms the bit.
  always_comb begin
    busy_nxt = busy_q;
    if (wen_q && from_lsu_q) busy_nxt[rd_q] = 1'b0;
    if (bus.issue_en && (bus.issue_rd != 5'd0)) busy_nxt[bus.issue_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_nxt;
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench for writeback_arbiter: per-cycle vector tables for the
// arbitration scenarios, hand sequences for scoreboard/reset corners.
module tb_writeback_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  logic mon_en = 1'b0;

  writeback_arbiter_if bus();

  writeback_arbiter #(.QUEUE_DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic        alu_v;
    logic [4:0]  alu_rd;
    logic        lsu_v;
    logic [4:0]  lsu_rd;
    logic        exp_ar;
    logic        exp_lr;
    logic        exp_wr;
    logic [4:0]  exp_rd;
    logic [31:0] exp_data;
  } vec_t;

  wr_t  exp_q[$];
  vec_t tbl[$];

  function automatic logic [31:0] adata(input logic [4:0] rd);
    return 32'hA000_0000 | {27'd0, rd};
  endfunction

  function automatic logic [31:0] ldata(input logic [4:0] rd);
    return 32'hB000_0000 | {27'd0, rd};
  endfunction

  // win: 0 = no grant, 1 = ALU, 2 = LSU head
  function automatic vec_t mk(input logic av, input logic [4:0] ard,
                              input logic lv, input logic [4:0] lrd,
                              input logic ar, input logic lr,
                              input int win, input logic [4:0] wrd);
    vec_t v;
    v.alu_v    = av;
    v.alu_rd   = ard;
    v.lsu_v    = lv;
    v.lsu_rd   = lrd;
    v.exp_ar   = ar;
    v.exp_lr   = lr;
    v.exp_wr   = (win != 0);
    v.exp_rd   = wrd;
    v.exp_data = (win == 1) ? adata(wrd) : ldata(wrd);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [4:0] rd, input logic [31:0] data);
    wr_t e;
    e.rd = rd;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic idle_inputs();
    bus.alu_valid = 1'b0;
    bus.alu_rd    = '0;
    bus.alu_data  = '0;
    bus.lsu_valid = 1'b0;
    bus.lsu_rd    = '0;
    bus.lsu_data  = '0;
    bus.issue_en  = 1'b0;
    bus.issue_rd  = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  task automatic run_table();
    foreach (tbl[i]) begin
      tick();
      bus.alu_valid = tbl[i].alu_v;
      bus.alu_rd    = tbl[i].alu_rd;
      bus.alu_data  = adata(tbl[i].alu_rd);
      bus.lsu_valid = tbl[i].lsu_v;
      bus.lsu_rd    = tbl[i].lsu_rd;
      bus.lsu_data  = ldata(tbl[i].lsu_rd);
      #1;
      chk($sformatf("alu_ready[%0d]", i), {31'd0, bus.alu_ready}, {31'd0, tbl[i].exp_ar});
      chk($sformatf("lsu_ready[%0d]", i), {31'd0, bus.lsu_ready}, {31'd0, tbl[i].exp_lr});
      if (tbl[i].exp_wr) push_exp(tbl[i].exp_rd, tbl[i].exp_data);
    end
    tick();
    idle_inputs();
    repeat (3) tick();
    chk("queue_drained", exp_q.size(), 0);
  endtask

  // Write-port monitor: every visible write must match the next expected one.
  always @(negedge clk) begin
    wr_t e;
    if (mon_en && rst_n && bus.reg_write_en) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write actual rd=%0d data=%h required=none",
                 bus.rd_addr, bus.write_data);
      end else begin
        e = exp_q.pop_front();
        chk("wr_rd", bus.rd_addr, e.rd);
        chk("wr_data", bus.write_data, e.data);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    #12;
    chk("rst_wen", {31'd0, bus.reg_write_en}, 0);
    chk("rst_rd", bus.rd_addr, 0);
    chk("rst_data", bus.write_data, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_lsu_ready", {31'd0, bus.lsu_ready}, 1);
    #1 rst_n = 1'b1;
    mon_en = 1'b1;

    // ALU only
    tick();
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd5;
    bus.alu_data  = 32'h1234_5678;
    #1 chk("alu_only_ready", {31'd0, bus.alu_ready}, 1);
    push_exp(5'd5, 32'h1234_5678);
    tick();
    idle_inputs();
    chk("alu_only_wen1", {31'd0, bus.reg_write_en}, 1);
    chk("alu_only_rd", bus.rd_addr, 5);
    chk("alu_only_data", bus.write_data, 32'h1234_5678);
    tick();
    chk("alu_only_wen0", {31'd0, bus.reg_write_en}, 0);
    chk("alu_only_hold", bus.write_data, 32'h1234_5678);

    // x0 write is consumed silently; issue to x0 never sets busy
    tick();
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd0;
    bus.alu_data  = 32'hFFFF_0000;
    bus.issue_en  = 1'b1;
    bus.issue_rd  = 5'd0;
    #1 chk("x0_ready", {31'd0, bus.alu_ready}, 1);
    tick();
    idle_inputs();
    chk("x0_wen", {31'd0, bus.reg_write_en}, 0);
    chk("x0_busy", bus.busy, 0);

    // LSU write with scoreboard tracking
    tick();
    bus.issue_en = 1'b1;
    bus.issue_rd = 5'd3;
    tick();
    idle_inputs();
    chk("sb_busy_set", bus.busy, 32'h0000_0008);
    tick();
    chk("sb_busy_hold", bus.busy, 32'h0000_0008);
    bus.lsu_valid = 1'b1;
    bus.lsu_rd    = 5'd3;
    bus.lsu_data  = 32'hDEAD_BEEF;
    #1 chk("sb_lsu_ready", {31'd0, bus.lsu_ready}, 1);
    push_exp(5'd3, 32'hDEAD_BEEF);
    tick();
    idle_inputs();
    chk("sb_no_bypass", {31'd0, bus.reg_write_en}, 0);
    tick();
    chk("sb_wen", {31'd0, bus.reg_write_en}, 1);
    chk("sb_rd", bus.rd_addr, 3);
    chk("sb_busy_during_write", bus.busy, 32'h0000_0008);
    tick();
    chk("sb_busy_clear", bus.busy, 0);

    // Set wins over clear on the same edge
    tick();
    bus.issue_en = 1'b1;
    bus.issue_rd = 5'd9;
    tick();
    idle_inputs();
    chk("col_busy_set", {31'd0, bus.busy[9]}, 1);
    bus.lsu_valid = 1'b1;
    bus.lsu_rd    = 5'd9;
    bus.lsu_data  = 32'h0909_0909;
    push_exp(5'd9, 32'h0909_0909);
    tick();
    idle_inputs();
    tick();
    chk("col_wen", {31'd0, bus.reg_write_en}, 1);
    chk("col_rd", bus.rd_addr, 9);
    bus.issue_en = 1'b1;
    bus.issue_rd = 5'd9;
    tick();
    idle_inputs();
    chk("col_busy_kept", bus.busy, 32'h0000_0200);

    // Contention: ALU first after reset, then alternate
    do_reset();
    tbl.delete();
    tbl.push_back(mk(1'b0, 5'd0, 1'b1, 5'd6, 1'b0, 1'b1, 0, 5'd0));
    tbl.push_back(mk(1'b1, 5'd1, 1'b1, 5'd7, 1'b1, 1'b1, 1, 5'd1));
    tbl.push_back(mk(1'b1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 2, 5'd6));
    tbl.push_back(mk(1'b1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b1, 1, 5'd2));
    tbl.push_back(mk(1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 1'b1, 2, 5'd7));
    tbl.push_back(mk(1'b1, 5'd3, 1'b0, 5'd0, 1'b1, 1'b1, 1, 5'd3));
    tbl.push_back(mk(1'b1, 5'd4, 1'b0, 5'd0, 1'b1, 1'b1, 1, 5'd4));
    run_table();

    // Backpressure: three back-to-back LSU pushes into a 2-deep FIFO
    do_reset();
    tbl.delete();
    tbl.push_back(mk(1'b1, 5'd10, 1'b1, 5'd20, 1'b1, 1'b1, 1, 5'd10));
    tbl.push_back(mk(1'b1, 5'd11, 1'b1, 5'd21, 1'b1, 1'b1, 1, 5'd11));
    tbl.push_back(mk(1'b1, 5'd12, 1'b1, 5'd22, 1'b0, 1'b0, 2, 5'd20));
    tbl.push_back(mk(1'b1, 5'd12, 1'b1, 5'd22, 1'b1, 1'b1, 1, 5'd12));
    tbl.push_back(mk(1'b1, 5'd13, 1'b0, 5'd0,  1'b0, 1'b0, 2, 5'd21));
    tbl.push_back(mk(1'b1, 5'd13, 1'b0, 5'd0,  1'b1, 1'b1, 1, 5'd13));
    tbl.push_back(mk(1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 1'b1, 2, 5'd22));
    run_table();

    // Asynchronous reset with a full FIFO and pending busy bits
    do_reset();
    tick();
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd1;
    bus.alu_data  = adata(5'd1);
    bus.lsu_valid = 1'b1;
    bus.lsu_rd    = 5'd3;
    bus.lsu_data  = ldata(5'd3);
    bus.issue_en  = 1'b1;
    bus.issue_rd  = 5'd3;
    push_exp(5'd1, adata(5'd1));
    tick();
    bus.alu_rd    = 5'd2;
    bus.alu_data  = adata(5'd2);
    bus.lsu_rd    = 5'd6;
    bus.lsu_data  = ldata(5'd6);
    bus.issue_rd  = 5'd6;
    #1 chk("rm_alu_ready", {31'd0, bus.alu_ready}, 1);
    tick();
    idle_inputs();
    chk("rm_busy_pre", bus.busy, 32'h0000_0048);
    chk("rm_full", {31'd0, bus.lsu_ready}, 0);
    chk("rm_wen_pre", {31'd0, bus.reg_write_en}, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rm_wen", {31'd0, bus.reg_write_en}, 0);
    chk("rm_rd", bus.rd_addr, 0);
    chk("rm_data", bus.write_data, 0);
    chk("rm_busy", bus.busy, 0);
    chk("rm_lsu_ready", {31'd0, bus.lsu_ready}, 1);
    @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (4) tick();
    chk("rm_quiet_wen", {31'd0, bus.reg_write_en}, 0);
    chk("rm_quiet_busy", bus.busy, 0);
    chk("rm_quiet_ready", {31'd0, bus.lsu_ready}, 1);

    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd8;
    bus.alu_data  = 32'h0808_0808;
    push_exp(5'd8, 32'h0808_0808);
    tick();
    idle_inputs();
    repeat (2) tick();
    chk("final_queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
